// File: rtl/svi_lane_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | svi_lane_collector: packs 8-lane x/y/z samples into words and buffers them |
// | in a FIFO that feeds a valid/ready stream. Optional: SVI_COLLECT_PARITY_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module svi_lane_collector #(
  parameter int LANES      = 8,
  parameter int DEPTH      = 4,
  parameter int FILTER_DUP = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [LANES-1:0]       i_x,
  input  logic [LANES-1:0]       i_y,
  input  logic [LANES-1:0]       i_z,
  output logic                   o_ready,
  output logic                   o_valid,
  output logic [3*LANES-1:0]     o_data,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [7:0]             o_drop_cnt,
  output logic                   o_ovf
`ifdef SVI_COLLECT_PARITY_EN
  ,
  output logic                   o_parity
`endif
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_dw = 3 * LANES;

  logic [c_dw-1:0] r_mem [DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic [c_dw-1:0] r_last;
  logic            r_last_vld;
  logic [7:0]      r_drop_cnt;
  logic            r_ovf;

  logic [c_dw-1:0] w_word;
  logic            w_full;
  logic            w_empty;
  logic            w_dup;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;

  assign w_word  = {i_z, i_y, i_x};
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_dup   = (FILTER_DUP != 0) && r_last_vld && (w_word == r_last);
  assign w_push  = i_valid && !w_full && !w_dup;
  assign w_pop   = !w_empty && i_ready;
  assign w_drop  = i_valid && w_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if ((FILTER_DUP != 0) && w_push) begin
        r_last     <= w_word;
        r_last_vld <= 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= w_word;
    end
  end

  assign o_valid    = !w_empty;
  assign o_ready    = !w_full;
  assign o_level    = r_wr_ptr - r_rd_ptr;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];
  assign o_drop_cnt = r_drop_cnt;
  assign o_ovf      = r_ovf;

`ifdef SVI_COLLECT_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_par[r_wr_ptr[c_aw-1:0]] <= ^w_word;
    end
  end

  assign o_parity = w_empty ? 1'b0 : r_par[r_rd_ptr[c_aw-1:0]];
`endif

endmodule
`default_nettype wire

// File: tb/tb_svi_lane_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_svi_lane_collector: table vectors, directed corner sequences and random |
// | traffic against a queue model, for FILTER_DUP=0 and FILTER_DUP=1.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_svi_lane_collector;

  localparam int DEPTH = 4;
  localparam int DW    = 24;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic ready = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic [7:0] z = '0;

  logic          rdy0, vld0, ovf0, rdy1, vld1, ovf1;
  logic [DW-1:0] dat0, dat1;
  logic [LW-1:0] lvl0, lvl1;
  logic [7:0]    drp0, drp1;
`ifdef SVI_COLLECT_PARITY_EN
  logic par0, par1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  svi_lane_collector #(.LANES(8), .DEPTH(DEPTH), .FILTER_DUP(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_x(x), .i_y(y), .i_z(z),
    .o_ready(rdy0), .o_valid(vld0), .o_data(dat0), .i_ready(ready),
    .o_level(lvl0), .o_drop_cnt(drp0), .o_ovf(ovf0)
`ifdef SVI_COLLECT_PARITY_EN
    , .o_parity(par0)
`endif
  );

  svi_lane_collector #(.LANES(8), .DEPTH(DEPTH), .FILTER_DUP(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_x(x), .i_y(y), .i_z(z),
    .o_ready(rdy1), .o_valid(vld1), .o_data(dat1), .i_ready(ready),
    .o_level(lvl1), .o_drop_cnt(drp1), .o_ovf(ovf1)
`ifdef SVI_COLLECT_PARITY_EN
    , .o_parity(par1)
`endif
  );

  // Reference model: an ordered list of queued words per instance.
  logic [DW-1:0] mq [2][64];
  int            mcnt [2];
  int            mdrop [2];
  bit            movf [2];
  logic [DW-1:0] mlast [2];
  bit            mlv [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      mcnt[f] = 0; mdrop[f] = 0; movf[f] = 0; mlast[f] = '0; mlv[f] = 0;
    end
  endtask

  task automatic model_update();
    logic [DW-1:0] w;
    w = {z, y, x};
    for (int f = 0; f < 2; f++) begin
      int pre;
      bit dup;
      pre = mcnt[f];
      dup = (f == 1) && mlv[f] && (w == mlast[f]);
      if (pre > 0 && ready) begin
        for (int i = 0; i < pre - 1; i++) mq[f][i] = mq[f][i+1];
        mcnt[f]--;
      end
      if (valid && pre < DEPTH && !dup) begin
        mq[f][mcnt[f]] = w;
        mcnt[f]++;
        if (f == 1) begin mlast[f] = w; mlv[f] = 1; end
      end
      if (valid && pre >= DEPTH) begin
        movf[f] = 1;
        if (mdrop[f] < 255) mdrop[f]++;
      end
    end
  endtask

  task automatic check_dut(input int f, input logic v, input logic r, input logic [DW-1:0] d,
                           input logic [LW-1:0] l, input logic [7:0] dc, input logic ov);
    logic [DW-1:0] hd;
    hd = (mcnt[f] > 0) ? mq[f][0] : '0;
    check($sformatf("dut%0d valid", f), v, mcnt[f] > 0);
    check($sformatf("dut%0d ready", f), r, mcnt[f] < DEPTH);
    check($sformatf("dut%0d data", f), d, hd);
    check($sformatf("dut%0d level", f), l, mcnt[f]);
    check($sformatf("dut%0d drop", f), dc, mdrop[f]);
    check($sformatf("dut%0d ovf", f), ov, movf[f]);
  endtask

  task automatic check_model();
    check_dut(0, vld0, rdy0, dat0, lvl0, drp0, ovf0);
    check_dut(1, vld1, rdy1, dat1, lvl1, drp1, ovf1);
`ifdef SVI_COLLECT_PARITY_EN
    check("dut0 parity", par0, (mcnt[0] > 0) ? ^mq[0][0] : 1'b0);
    check("dut1 parity", par1, (mcnt[1] > 0) ? ^mq[1][0] : 1'b0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    valid = 0; ready = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] w, input logic r);
    valid = v; {z, y, x} = w; ready = r;
  endtask

  typedef struct {
    logic          v;
    logic [DW-1:0] w;
    logic          r;
    logic          ev;
    logic [LW-1:0] el;
    logic [DW-1:0] ed;
    logic [7:0]    edrop;
    logic          eovf;
    logic          erdy;
  } vec_t;

  function automatic vec_t mk(logic v, logic [DW-1:0] w, logic r, logic ev, logic [LW-1:0] el,
                              logic [DW-1:0] ed, logic [7:0] edrop, logic eovf, logic erdy);
    vec_t t;
    t.v = v; t.w = w; t.r = r; t.ev = ev; t.el = el; t.ed = ed;
    t.edrop = edrop; t.eovf = eovf; t.erdy = erdy;
    return t;
  endfunction

  function automatic logic [DW-1:0] wk(int k);
    logic [7:0] b;
    b = 8'(k);
    return {b + 8'h20, b + 8'h10, b + 8'h01};
  endfunction

  vec_t tbl [12];

  initial begin
    logic [DW-1:0] w;
    int sel;

    // Single push/pop, fill to overflow, full push+pop, then drain.
    tbl[0] = mk(1, 24'hFF00FF, 0, 1, 1, 24'hFF00FF, 0, 0, 1);
    tbl[1] = mk(0, 24'h000000, 1, 0, 0, 24'h000000, 0, 0, 1);
    for (int k = 0; k < 6; k++)
      tbl[2+k] = mk(1, wk(k), 0, 1, LW'((k < 3) ? k + 1 : 4), wk(0),
                    8'((k > 3) ? k - 3 : 0), k >= 4, k < 3);
    tbl[8]  = mk(1, wk(6), 1, 1, 3, wk(1), 3, 1, 1);
    tbl[9]  = mk(0, '0,    1, 1, 2, wk(2), 3, 1, 1);
    tbl[10] = mk(0, '0,    1, 1, 1, wk(3), 3, 1, 1);
    tbl[11] = mk(0, '0,    1, 0, 0, '0,    3, 1, 1);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].r);
      step();
      check($sformatf("vec%0d valid", i), vld0, tbl[i].ev);
      check($sformatf("vec%0d level", i), lvl0, tbl[i].el);
      check($sformatf("vec%0d data", i), dat0, tbl[i].ed);
      check($sformatf("vec%0d drop", i), drp0, tbl[i].edrop);
      check($sformatf("vec%0d ovf", i), ovf0, tbl[i].eovf);
      check($sformatf("vec%0d ready", i), rdy0, tbl[i].erdy);
    end

    // Duplicate filtering: three identical samples then a new one.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, (i < 3) ? 24'hFF00FF : 24'h00FF00, 0);
      step();
    end
    check("filter level", lvl1, 2);
    check("filter drop", drp1, 0);
    check("nofilter level", lvl0, 4);
    check("nofilter drop", drp0, 0);

    // Full-rate streaming across several pointer wraps.
    do_reset();
    drive(1, 24'h0, 1);
    step();
    for (int k = 1; k <= 20; k++) begin
      drive(1, {3{8'(k)}}, 1);
      step();
      check($sformatf("stream%0d level", k), lvl0, 1);
      check($sformatf("stream%0d data", k), dat0, {3{8'(k)}});
    end

    // Asynchronous reset with words queued and drops counted.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1, wk(k + 40), 0);
      step();
    end
    drive(0, '0, 1);
    step();
    ready = 0;
    check("pre-rst level", lvl0, 3);
    check("pre-rst drop", drp0, 5);
    #3;
    rst = 1;
    #1;
    model_reset();
    check("arst valid", vld0, 0);
    check("arst level", lvl0, 0);
    check("arst drop", drp0, 0);
    check("arst ovf", ovf0, 0);
    check("arst ready", rdy0, 1);
    check("arst data", dat0, 0);
    check("arst f level", lvl1, 0);
    #2;
    rst = 0;
    drive(1, 24'h123456, 0);
    #1;
    check("post-rst idle valid", vld0, 0);
    step();
    check("post-rst push valid", vld0, 1);
    check("post-rst push data", dat0, 24'h123456);

    // Random traffic with frequent repeats to exercise the filter.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 3);
      w = (sel == 0) ? 24'h0 : {3{8'(sel * 8'h35)}};
      drive($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) == 0);
      step();
    end

    // Drive enough overflow to reach saturation.
    for (int n = 0; n < 300; n++) begin
      drive(1, {3{8'(n)}}, 0);
      step();
    end
    check("sat drop0", drp0, 255);
    check("sat drop1", drp1, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
